// File: rtl/hpm_pkg.sv
// Performance-monitor event IDs and the width helpers shared by the counter
// unit and its per-counter event selectors.
package hpm_pkg;

  typedef enum logic [4:0] {
    HPM_EV_NONE              = 5'd0,
    HPM_EV_BRANCH_MISS       = 5'd1,
    HPM_EV_INSTR_RETIRED     = 5'd2,
    HPM_EV_LOAD_RETIRED      = 5'd3,
    HPM_EV_STORE_RETIRED     = 5'd4,
    HPM_EV_BRANCH_RETIRED    = 5'd5,
    HPM_EV_JUMP_RETIRED      = 5'd6,
    HPM_EV_CALL_RETIRED      = 5'd7,
    HPM_EV_RET_RETIRED       = 5'd8,
    HPM_EV_RET_MISS          = 5'd9,
    HPM_EV_JUMP_MISS         = 5'd10,
    HPM_EV_ICACHE_ACCESS     = 5'd11,
    HPM_EV_ICACHE_MISS       = 5'd12,
    HPM_EV_DCACHE_ACCESS     = 5'd13,
    HPM_EV_DCACHE_MISS       = 5'd14,
    HPM_EV_DCACHE_WRITEBACK  = 5'd15,
    HPM_EV_DTLB_ACCESS       = 5'd16,
    HPM_EV_DTLB_MISS         = 5'd17,
    HPM_EV_ITLB_ACCESS       = 5'd18,
    HPM_EV_ITLB_MISS         = 5'd19,
    HPM_EV_FETCH_STALL       = 5'd20,
    HPM_EV_ISSUE_STALL       = 5'd21,
    HPM_EV_LSU_STALL         = 5'd22,
    HPM_EV_MUL_DIV_OP        = 5'd23,
    HPM_EV_FPU_OP            = 5'd24,
    HPM_EV_AMO_OP            = 5'd25,
    HPM_EV_EXCEPTION         = 5'd26,
    HPM_EV_DTLB_MISS_CYCLE   = 5'd27,
    HPM_EV_ITLB_MISS_CYCLE   = 5'd28
  } hpm_event_e;

  // Overflow flag position inside an mhpmevent CSR.
  localparam int HPM_OF_BIT = 63;

  function automatic int sel_width(input int num_events);
    return $clog2(num_events + 1);
  endfunction

  function automatic int inc_width(input int event_lanes);
    return $clog2(event_lanes + 1);
  endfunction

endpackage

// File: rtl/riscv_pkg.sv
// CSR address map shared by the CSR file and the units it forwards accesses to.
// Only the ranges this counter block decodes are listed here.
package riscv_pkg;

  localparam int CSR_ADDR_SIZE = 12;

  localparam logic [CSR_ADDR_SIZE-1:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [CSR_ADDR_SIZE-1:0] CSR_MHPMEVENT3    = 12'h323;
  localparam logic [CSR_ADDR_SIZE-1:0] CSR_MHPMCOUNTER3  = 12'hB03;

endpackage

// File: rtl/hpm_event_select.sv
// Per-counter event mux: popcount of the lanes of the selected event.
// IDs 0 and above NUM_EVENTS yield no increment.
module hpm_event_select
  import hpm_pkg::*;
#(
  parameter  int NUM_EVENTS  = 28,
  parameter  int EVENT_LANES = 2,
  localparam int SEL_W       = sel_width(NUM_EVENTS),
  localparam int INC_W       = inc_width(EVENT_LANES)
) (
  input  logic [SEL_W-1:0]                  sel,
  input  logic [NUM_EVENTS*EVENT_LANES-1:0] events,
  output logic [INC_W-1:0]                  inc
);

  // NOTE: blocking assignments in always_comb, with a default first so no latch is inferred.
  always_comb begin
    inc = '0;
    for (int e = 1; e <= NUM_EVENTS; e++) begin
      if (sel == SEL_W'(e)) begin
        for (int l = 0; l < EVENT_LANES; l++) begin
          inc = inc + INC_W'(events[(e-1)*EVENT_LANES + l]);
        end
      end
    end
  end

endmodule

// File: rtl/hpm_counter_unit.sv
// Hardware performance-monitor counters mhpmcounter3.. with event selectors,
// mcountinhibit, sticky overflow flags and the local overflow interrupt.
module hpm_counter_unit
  import hpm_pkg::*;
  import riscv_pkg::*;
#(
  parameter int NUM_COUNTERS = 29,
  parameter int NUM_EVENTS   = 28,
  parameter int EVENT_LANES  = 2,
  parameter int CNT_WIDTH    = 64
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,
  input  logic [CSR_ADDR_SIZE-1:0]          addr_i,
  input  logic                              we_i,
  input  logic [63:0]                       data_i,
  output logic [63:0]                       data_o,
  input  logic [NUM_EVENTS*EVENT_LANES-1:0] events_i,
  output logic                              lcofi_o
);

  localparam int SEL_W = sel_width(NUM_EVENTS);
  localparam int INC_W = inc_width(EVENT_LANES);

  logic [CNT_WIDTH-1:0]    counter_q [NUM_COUNTERS];
  logic [CNT_WIDTH-1:0]    counter_d [NUM_COUNTERS];
  logic [CNT_WIDTH:0]      sum       [NUM_COUNTERS];
  logic [SEL_W-1:0]        sel_q     [NUM_COUNTERS];
  logic [INC_W-1:0]        inc_q     [NUM_COUNTERS];
  logic [INC_W-1:0]        inc_d     [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] of_q, of_d;
  logic [NUM_COUNTERS-1:0] cnt_we, evt_we;
  // Bit i mirrors mcountinhibit bit i+3.
  logic [NUM_COUNTERS-1:0] inhibit_q, inhibit_d;
  logic                    inhibit_we;

  for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_sel
    hpm_event_select #(
      .NUM_EVENTS  (NUM_EVENTS),
      .EVENT_LANES (EVENT_LANES)
    ) u_event_select (
      .sel    (sel_q[g]),
      .events (events_i),
      .inc    (inc_d[g])
    );
  end

  always_comb begin
    data_o     = '0;
    cnt_we     = '0;
    evt_we     = '0;
    of_d       = of_q;
    inhibit_we = we_i && (addr_i == CSR_MCOUNTINHIBIT);
    inhibit_d  = inhibit_we ? data_i[NUM_COUNTERS+2:3] : inhibit_q;

    if (addr_i == CSR_MCOUNTINHIBIT) data_o[NUM_COUNTERS+2:3] = inhibit_q;

    for (int i = 0; i < NUM_COUNTERS; i++) begin
      cnt_we[i]    = we_i && (addr_i == CSR_MHPMCOUNTER3 + CSR_ADDR_SIZE'(i));
      evt_we[i]    = we_i && (addr_i == CSR_MHPMEVENT3 + CSR_ADDR_SIZE'(i));
      sum[i]       = {1'b0, counter_q[i]} + (CNT_WIDTH+1)'(inc_q[i]);
      counter_d[i] = counter_q[i];

      if (evt_we[i]) of_d[i] = data_i[HPM_OF_BIT];

      // A software write wins over the staged increment and never flags overflow;
      // a hardware wrap wins over a same-cycle software clear.
      if (cnt_we[i]) begin
        counter_d[i] = data_i[CNT_WIDTH-1:0];
      end else if (!inhibit_d[i]) begin
        counter_d[i] = sum[i][CNT_WIDTH-1:0];
        if (sum[i][CNT_WIDTH]) of_d[i] = 1'b1;
      end

      if (addr_i == CSR_MHPMCOUNTER3 + CSR_ADDR_SIZE'(i)) data_o = 64'(counter_q[i]);
      if (addr_i == CSR_MHPMEVENT3 + CSR_ADDR_SIZE'(i)) begin
        data_o[SEL_W-1:0]   = sel_q[i];
        data_o[HPM_OF_BIT]  = of_q[i];
      end
    end
  end

  // NOTE: every counter, selector and staged increment is a flop that must reset;
  // this array is not a RAM, so resetting it costs nothing extra in structure.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        counter_q[i] <= '0;
        sel_q[i]     <= '0;
        inc_q[i]     <= '0;
      end
      of_q      <= '0;
      inhibit_q <= '0;
      lcofi_o   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        counter_q[i] <= counter_d[i];
        inc_q[i]     <= inhibit_d[i] ? '0 : inc_d[i];
        if (evt_we[i]) begin
          sel_q[i] <= (data_i[SEL_W-1:0] > SEL_W'(NUM_EVENTS)) ? '0 : data_i[SEL_W-1:0];
        end
      end
      of_q      <= of_d;
      inhibit_q <= inhibit_d;
      lcofi_o   <= |of_d;
    end
  end

endmodule
